irrigation_scheduler: RTL

- Sequences the irrigation valve from the trusted-event comparator's Output/Flag.
- Requires an event to persist before watering, times the watering window, then enforces a cooldown.
- Counts single-sensor fault indications and latches an alarm after too many, holding the valve closed until cleared.
- Sits between the comparator and the valve driver; all timing is in sample ticks (1 tick = 1 s in the system).

---
 rtl/irrigation_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/irrigation_scheduler.sv
// Purpose : sequences the irrigation valve from the comparator's trusted event/flag
//           (confirm -> irrigate -> cooldown) and latches an alarm after repeated faults.
// Latency : all outputs registered; a decision taken on cycle T is visible at T+1.
// Backpressure: none; timing advances only on sample_tick cycles, and the block always accepts input.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sample_tick       one-cycle timing strobe (1 tick = 1 s in the system)
//   enable            scheduler enable level
//   event_in, flag_in comparator Output / Flag
//   clear_fault       one-cycle pulse: leave FAULT, clear fault count
//   valve_open        valve drive
//   busy              high in CONFIRM, IRRIGATE, COOLDOWN
//   alarm             high in FAULT
//   event_count       confirmed irrigation events, saturating at 255
//   last_fault_flag   flag_in captured at the most recent fault indication
module irrigation_scheduler #(
    parameter int CONFIRM_TICKS  = 3,
    parameter int IRRIGATE_TICKS = 600,
    parameter int COOLDOWN_TICKS = 1800,
    parameter int FAULT_LIMIT    = 3,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick,
    input  logic       enable,
    input  logic       event_in,
    input  logic [2:0] flag_in,
    input  logic       clear_fault,
    output logic       valve_open,
    output logic       busy,
    output logic       alarm,
    output logic [7:0] event_count,
    output logic [2:0] last_fault_flag
);

    localparam int FCNT_W = $clog2(FAULT_LIMIT + 1);

    localparam logic [CNT_W-1:0]  CONFIRM_LAST  = CNT_W'(CONFIRM_TICKS - 1);
    localparam logic [CNT_W-1:0]  IRRIGATE_LAST = CNT_W'(IRRIGATE_TICKS - 1);
    localparam logic [CNT_W-1:0]  COOLDOWN_LAST = CNT_W'(COOLDOWN_TICKS - 1);
    localparam logic [FCNT_W-1:0] FAULT_MAX     = FCNT_W'(FAULT_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        CONFIRM,
        IRRIGATE,
        COOLDOWN,
        FAULT
    } stateT;

    stateT             state, stateNxt;
    logic [CNT_W-1:0]  cnt, cntNxt;
    logic [FCNT_W-1:0] faultCnt, faultCntNxt, faultCntInc;
    logic [7:0]        eventCountNxt;
    logic [2:0]        lastFlagNxt;
    logic              faultTick;

    always_comb begin
        stateNxt      = state;
        cntNxt        = cnt;
        faultCntNxt   = faultCnt;
        eventCountNxt = event_count;
        lastFlagNxt   = last_fault_flag;

        // Flag without an event is a single-sensor disagreement; not sampled while
        // the valve is open or while already latched in FAULT.
        faultTick = sample_tick && !event_in && (flag_in != 3'b000) &&
                    (state == IDLE || state == CONFIRM || state == COOLDOWN);
        faultCntInc = (faultCnt == FAULT_MAX) ? faultCnt : faultCnt + 1'b1;

        case (state)
            IDLE: begin
                if (sample_tick && enable && event_in) begin
                    stateNxt = CONFIRM;
                    cntNxt   = CNT_W'(1);
                end
            end
            CONFIRM: begin
                if (!enable) begin
                    stateNxt = IDLE;
                end else if (sample_tick) begin
                    if (!event_in) begin
                        stateNxt = IDLE;
                    end else if (cnt == CONFIRM_LAST) begin
                        stateNxt      = IRRIGATE;
                        cntNxt        = '0;
                        eventCountNxt = (event_count == 8'hFF) ? event_count
                                                               : event_count + 8'd1;
                        // A confirmed event vindicates the sensors.
                        faultCntNxt   = '0;
                    end else begin
                        cntNxt = cnt + 1'b1;
                    end
                end
            end
            IRRIGATE: begin
                // Abort takes priority over a coincident tick.
                if (!enable) begin
                    stateNxt = COOLDOWN;
                    cntNxt   = '0;
                end else if (sample_tick) begin
                    if (cnt == IRRIGATE_LAST) begin
                        stateNxt = COOLDOWN;
                        cntNxt   = '0;
                    end else begin
                        cntNxt = cnt + 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                if (sample_tick) begin
                    if (cnt == COOLDOWN_LAST) begin
                        stateNxt = IDLE;
                        cntNxt   = '0;
                    end else begin
                        cntNxt = cnt + 1'b1;
                    end
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    stateNxt    = IDLE;
                    faultCntNxt = '0;
                end
            end
            default: begin
                stateNxt = IDLE;
                cntNxt   = '0;
            end
        endcase

        // Fault accounting overlays the per-state decision. A simultaneous clear
        // discards the indication (no count, no trip) but the flag is still recorded.
        if (faultTick) begin
            lastFlagNxt = flag_in;
            if (!clear_fault) begin
                faultCntNxt = faultCntInc;
                if (faultCntInc == FAULT_MAX) begin
                    stateNxt = FAULT;
                    cntNxt   = '0;
                end
            end
        end
        if (clear_fault && state != FAULT) begin
            faultCntNxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            faultCnt        <= '0;
            event_count     <= 8'd0;
            last_fault_flag <= 3'b000;
            valve_open      <= 1'b0;
            busy            <= 1'b0;
            alarm           <= 1'b0;
        end else begin
            state           <= stateNxt;
            cnt             <= cntNxt;
            faultCnt        <= faultCntNxt;
            event_count     <= eventCountNxt;
            last_fault_flag <= lastFlagNxt;
            // Decoded from the next state so the pins track the state register exactly.
            valve_open      <= (stateNxt == IRRIGATE);
            busy            <= (stateNxt == CONFIRM) || (stateNxt == IRRIGATE) ||
                               (stateNxt == COOLDOWN);
            alarm           <= (stateNxt == FAULT);
        end
    end

endmodule
